// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave controller.
// Frame length default, bit counter width and FSM state encoding.
package spi_pkg;

   localparam int FRAME_BITS = 12;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } spi_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for one asynchronous input, with rise/fall detection
// taken from the second stage against a third registered copy.
module sync_edge_det
   import spi_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic n_rst,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q;
   logic s2_q;
   logic s3_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
         s3_q <= RST_VAL;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise_o = s2_q & ~s3_q;
   assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave frame controller: receives MSB-first MOSI words and
// generates load/pulse strobes for a downstream parallel-to-serial register.
module spi_slave_ctrl
   import spi_pkg::*;
#(
   parameter int NUM_BITS = FRAME_BITS
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                sck,
   input  logic                ss_n,
   input  logic                mosi,
   output logic                load,
   output logic                pulse,
   output logic [NUM_BITS-1:0] rx_data,
   output logic                rx_valid,
   output logic                frame_err,
   output logic                busy
);

   localparam int CW = (CNT_W > $clog2(NUM_BITS + 2)) ? CNT_W : $clog2(NUM_BITS + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(NUM_BITS);
   localparam logic [CW-1:0] CNT_SAT  = CW'(NUM_BITS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(NUM_BITS - 1);

   logic sck_rise, sck_fall;
   logic ss_rise, ss_fall;
   logic mosi_s1_q, mosi_s2_q;

   spi_state_e          state_q;
   logic [CW-1:0]       bit_cnt_q;
   logic [NUM_BITS-1:0] rx_sr_q;
   logic [NUM_BITS-1:0] rx_data_q;
   logic                load_q, pulse_q, rx_valid_q, frame_err_q, busy_q;

   sync_edge_det #(.RST_VAL(1'b0)) u_sck_sync (
      .clk    (clk),
      .n_rst  (n_rst),
      .d_i    (sck),
      .rise_o (sck_rise),
      .fall_o (sck_fall)
   );

   sync_edge_det #(.RST_VAL(1'b1)) u_ss_sync (
      .clk    (clk),
      .n_rst  (n_rst),
      .d_i    (ss_n),
      .rise_o (ss_rise),
      .fall_o (ss_fall)
   );

   // MOSI shares the sck synchronizer depth, so at a detected sck rise the
   // second stage holds the bit the master set up before that edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
      end else begin
         mosi_s1_q <= mosi;
         mosi_s2_q <= mosi_s1_q;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_sr_q     <= '0;
         rx_data_q   <= '0;
         load_q      <= 1'b0;
         pulse_q     <= 1'b0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         load_q      <= 1'b0;
         pulse_q     <= 1'b0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ss_fall) begin
                  state_q <= LOAD;
                  busy_q  <= 1'b1;
               end
            end
            LOAD: begin
               load_q    <= 1'b1;
               bit_cnt_q <= '0;
               rx_sr_q   <= '0;
               state_q   <= SHIFT;
            end
            SHIFT: begin
               // End of frame wins over any sck edge seen in the same cycle.
               if (ss_rise) begin
                  if (bit_cnt_q == CNT_FULL) begin
                     state_q <= DONE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= IDLE;
                     busy_q      <= 1'b0;
                  end
               end else if (sck_rise) begin
                  rx_sr_q <= {rx_sr_q[NUM_BITS-2:0], mosi_s2_q};
                  if (bit_cnt_q != CNT_SAT) begin
                     bit_cnt_q <= bit_cnt_q + CW'(1);
                  end
               end else if (sck_fall && (bit_cnt_q != '0) && (bit_cnt_q <= CNT_LAST)) begin
                  pulse_q <= 1'b1;
               end
            end
            DONE: begin
               rx_data_q  <= rx_sr_q;
               rx_valid_q <= 1'b1;
               if (ss_fall) begin
                  state_q <= LOAD;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign load      = load_q;
   assign pulse     = pulse_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: drives mode-0 SPI frames at clk/10 and
// checks strobe counts and received words against hand-computed values.
module tb_spi_slave_ctrl;

   logic        clk;
   logic        n_rst;
   logic        sck;
   logic        ss_n;
   logic        mosi;
   logic        load;
   logic        pulse;
   logic [11:0] rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   int load_cnt = 0;
   int pulse_cnt = 0;
   int rxv_cnt = 0;
   int ferr_cnt = 0;
   int ovl_cnt = 0;
   logic [11:0] rx_log[$];
   logic [11:0] exp_q[$];

   spi_slave_ctrl #(.NUM_BITS(12)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .sck       (sck),
      .ss_n      (ss_n),
      .mosi      (mosi),
      .load      (load),
      .pulse     (pulse),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (load) load_cnt++;
      if (pulse) pulse_cnt++;
      if (frame_err) ferr_cnt++;
      if (rx_valid) begin
         rxv_cnt++;
         rx_log.push_back(rx_data);
      end
      if ((int'(load) + int'(pulse) + int'(rx_valid) + int'(frame_err)) > 1) ovl_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_counts();
      load_cnt = 0;
      pulse_cnt = 0;
      rxv_cnt = 0;
      ferr_cnt = 0;
      rx_log.delete();
   endtask

   task automatic drive_bits(input logic [11:0] word, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         if (i < 12) mosi = word[11-i];
         else mosi = 1'b0;
         wait_clk(5);
         sck = 1'b1;
         wait_clk(5);
         sck = 1'b0;
      end
      wait_clk(5);
   endtask

   task automatic drive_frame(input logic [11:0] word, input int nbits, input int gap);
      ss_n = 1'b0;
      wait_clk(4);
      drive_bits(word, nbits);
      ss_n = 1'b1;
      wait_clk(gap);
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      sck = 1'b0;
      ss_n = 1'b1;
      mosi = 1'b0;
      wait_clk(5);
      n_cmp++;
      if ({load, pulse, rx_valid, frame_err, busy} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_strobes: got %b want 00000", {load, pulse, rx_valid, frame_err, busy});
      end
      n_cmp++;
      if (rx_data !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_rx_data: got %h want 000", rx_data);
      end
      n_rst = 1'b1;
      wait_clk(5);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_good_frame();
      clear_counts();
      drive_frame(12'hA5C, 12, 12);
      n_cmp++;
      if (load_cnt !== 1) begin
         n_bad++;
         $display("FAIL good_load_cnt: got %0d want 1", load_cnt);
      end
      n_cmp++;
      if (pulse_cnt !== 11) begin
         n_bad++;
         $display("FAIL good_pulse_cnt: got %0d want 11", pulse_cnt);
      end
      n_cmp++;
      if (rxv_cnt !== 1) begin
         n_bad++;
         $display("FAIL good_rxv_cnt: got %0d want 1", rxv_cnt);
      end
      n_cmp++;
      if (ferr_cnt !== 0) begin
         n_bad++;
         $display("FAIL good_ferr_cnt: got %0d want 0", ferr_cnt);
      end
      n_cmp++;
      if (rx_data !== 12'hA5C) begin
         n_bad++;
         $display("FAIL good_rx_data: got %h want a5c", rx_data);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL good_busy_after: got %b want 0", busy);
      end
   endtask

   task automatic test_short_frame();
      clear_counts();
      drive_frame(12'h3C3, 8, 12);
      n_cmp++;
      if (ferr_cnt !== 1) begin
         n_bad++;
         $display("FAIL short_ferr_cnt: got %0d want 1", ferr_cnt);
      end
      n_cmp++;
      if (rxv_cnt !== 0) begin
         n_bad++;
         $display("FAIL short_rxv_cnt: got %0d want 0", rxv_cnt);
      end
      n_cmp++;
      if (pulse_cnt !== 8) begin
         n_bad++;
         $display("FAIL short_pulse_cnt: got %0d want 8", pulse_cnt);
      end
      n_cmp++;
      if (rx_data !== 12'hA5C) begin
         n_bad++;
         $display("FAIL short_rx_data: got %h want a5c", rx_data);
      end
   endtask

   task automatic test_overrun_frame();
      clear_counts();
      drive_frame(12'h0F0, 13, 12);
      n_cmp++;
      if (ferr_cnt !== 1) begin
         n_bad++;
         $display("FAIL overrun_ferr_cnt: got %0d want 1", ferr_cnt);
      end
      n_cmp++;
      if (rxv_cnt !== 0) begin
         n_bad++;
         $display("FAIL overrun_rxv_cnt: got %0d want 0", rxv_cnt);
      end
      n_cmp++;
      if (pulse_cnt !== 11) begin
         n_bad++;
         $display("FAIL overrun_pulse_cnt: got %0d want 11", pulse_cnt);
      end
      n_cmp++;
      if (rx_data !== 12'hA5C) begin
         n_bad++;
         $display("FAIL overrun_rx_data: got %h want a5c", rx_data);
      end
   endtask

   task automatic test_reset_abort();
      clear_counts();
      ss_n = 1'b0;
      wait_clk(4);
      drive_bits(12'hFFF, 6);
      n_cmp++;
      if (pulse_cnt !== 6) begin
         n_bad++;
         $display("FAIL abort_pulses_before: got %0d want 6", pulse_cnt);
      end
      clear_counts();
      n_rst = 1'b0;
      wait_clk(3);
      ss_n = 1'b1;
      wait_clk(2);
      n_rst = 1'b1;
      wait_clk(10);
      n_cmp++;
      if ((load_cnt + pulse_cnt + rxv_cnt + ferr_cnt) !== 0) begin
         n_bad++;
         $display("FAIL abort_strobes: got %0d want 0", load_cnt + pulse_cnt + rxv_cnt + ferr_cnt);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_busy: got %b want 0", busy);
      end
      n_cmp++;
      if (rx_data !== 12'h000) begin
         n_bad++;
         $display("FAIL abort_rx_data: got %h want 000", rx_data);
      end
      drive_frame(12'h123, 12, 12);
      n_cmp++;
      if (rx_data !== 12'h123) begin
         n_bad++;
         $display("FAIL abort_next_rx_data: got %h want 123", rx_data);
      end
      n_cmp++;
      if (rxv_cnt !== 1) begin
         n_bad++;
         $display("FAIL abort_next_rxv_cnt: got %0d want 1", rxv_cnt);
      end
   endtask

   task automatic test_ss_low_at_reset();
      clear_counts();
      n_rst = 1'b0;
      ss_n = 1'b0;
      wait_clk(3);
      n_rst = 1'b1;
      wait_clk(6);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL sslow_busy: got %b want 1", busy);
      end
      drive_bits(12'h5A3, 12);
      ss_n = 1'b1;
      wait_clk(12);
      n_cmp++;
      if (rx_data !== 12'h5A3) begin
         n_bad++;
         $display("FAIL sslow_rx_data: got %h want 5a3", rx_data);
      end
      n_cmp++;
      if (load_cnt !== 1) begin
         n_bad++;
         $display("FAIL sslow_load_cnt: got %0d want 1", load_cnt);
      end
   endtask

   task automatic test_back_to_back();
      clear_counts();
      exp_q.delete();
      exp_q.push_back(12'hFFF);
      exp_q.push_back(12'h001);
      drive_frame(12'hFFF, 12, 2);
      drive_frame(12'h001, 12, 12);
      n_cmp++;
      if (load_cnt !== 2) begin
         n_bad++;
         $display("FAIL b2b_load_cnt: got %0d want 2", load_cnt);
      end
      n_cmp++;
      if (rxv_cnt !== 2) begin
         n_bad++;
         $display("FAIL b2b_rxv_cnt: got %0d want 2", rxv_cnt);
      end
      n_cmp++;
      if (ferr_cnt !== 0) begin
         n_bad++;
         $display("FAIL b2b_ferr_cnt: got %0d want 0", ferr_cnt);
      end
      while (exp_q.size() > 0) begin
         logic [11:0] exp_w;
         logic [11:0] got_w;
         exp_w = exp_q.pop_front();
         got_w = (rx_log.size() > 0) ? rx_log.pop_front() : 12'hxxx;
         n_cmp++;
         if (got_w !== exp_w) begin
            n_bad++;
            $display("FAIL b2b_word: got %h want %h", got_w, exp_w);
         end
      end
   endtask

   task automatic test_exclusive_strobes();
      n_cmp++;
      if (ovl_cnt !== 0) begin
         n_bad++;
         $display("FAIL strobe_overlap: got %0d cycles want 0", ovl_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_short_frame();
      test_overrun_frame();
      test_reset_abort();
      test_ss_low_at_reset();
      test_back_to_back();
      test_exclusive_strobes();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
